// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: register map and frame constants shared by the SPI register controller.
package spi_reg_pkg;
    localparam logic [6:0] ADDR_OUT_LO = 7'h00;
    localparam logic [6:0] ADDR_OUT_HI = 7'h01;
    localparam logic [6:0] ADDR_PWM_LO = 7'h02;
    localparam logic [6:0] ADDR_PWM_HI = 7'h03;
    localparam logic [6:0] ADDR_DUTY   = 7'h04;
    localparam logic [6:0] MAX_ADDR    = 7'h04;
    localparam logic [4:0] FRAME_BITS  = 5'd16;
    localparam logic [4:0] CNT_SAT     = 5'd17;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer + history flop; ports clk, rst, d (async in), lvl (synced level), rise/fall (registered one-clk edge pulses).
module sync_edge_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic lvl,
    output logic rise,
    output logic fall
);
    logic s1_q, s2_q, h_q, rise_q, fall_q;
    logic rise_d, fall_d;
    always_comb begin
        rise_d = s2_q & ~h_q;
        fall_d = ~s2_q & h_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q   <= RST_VAL;
            s2_q   <= RST_VAL;
            h_q    <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            s1_q   <= d;
            s2_q   <= s1_q;
            h_q    <= s2_q;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end
    // lvl is the history flop, so it lines up with the registered edge pulses
    assign lvl  = h_q;
    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI mode-0 write-only register file; ports clk, rst, sclk/copi/ncs (async SPI), five 8-bit config registers, wr_strobe, frame_err pulses.
module spi_reg_ctrl
    import spi_reg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       wr_strobe,
    output logic       frame_err
);
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic copi_lvl, copi_rise, copi_fall;
    logic ncs_lvl, ncs_rise, ncs_fall;
    logic unused_edges;
    sync_edge_det #(.RST_VAL(1'b0)) u_sclk (.clk(clk), .rst(rst), .d(sclk), .lvl(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    sync_edge_det #(.RST_VAL(1'b0)) u_copi (.clk(clk), .rst(rst), .d(copi), .lvl(copi_lvl), .rise(copi_rise), .fall(copi_fall));
    sync_edge_det #(.RST_VAL(1'b1)) u_ncs  (.clk(clk), .rst(rst), .d(ncs),  .lvl(ncs_lvl),  .rise(ncs_rise),  .fall(ncs_fall));
    assign unused_edges = ^{sclk_lvl, sclk_fall, copi_rise, copi_fall};
    logic [15:0] sr_q, sr_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        armed_q, armed_d;
    logic [7:0]  out_lo_q, out_lo_d, out_hi_q, out_hi_d;
    logic [7:0]  pwm_lo_q, pwm_lo_d, pwm_hi_q, pwm_hi_d, duty_q, duty_d;
    logic        wr_q, wr_d, err_q, err_d;
    logic        sample, commit;
    always_comb begin
        // a sclk edge coinciding with ncs deassertion is dropped
        sample   = sclk_rise & ~ncs_lvl & ~ncs_rise;
        // armed guards against an ncs rise with no falling edge since reset
        commit   = ncs_rise & armed_q & (cnt_q == FRAME_BITS) & sr_q[15] & (sr_q[14:8] <= MAX_ADDR);
        err_d    = ncs_rise & armed_q & (cnt_q != FRAME_BITS);
        wr_d     = commit;
        sr_d     = ncs_fall ? 16'h0000 : sample ? {sr_q[14:0], copi_lvl} : sr_q;
        cnt_d    = ncs_fall ? 5'd0 : (sample && cnt_q != CNT_SAT) ? cnt_q + 5'd1 : cnt_q;
        armed_d  = ncs_fall ? 1'b1 : ncs_rise ? 1'b0 : armed_q;
        out_lo_d = (commit && sr_q[14:8] == ADDR_OUT_LO) ? sr_q[7:0] : out_lo_q;
        out_hi_d = (commit && sr_q[14:8] == ADDR_OUT_HI) ? sr_q[7:0] : out_hi_q;
        pwm_lo_d = (commit && sr_q[14:8] == ADDR_PWM_LO) ? sr_q[7:0] : pwm_lo_q;
        pwm_hi_d = (commit && sr_q[14:8] == ADDR_PWM_HI) ? sr_q[7:0] : pwm_hi_q;
        duty_d   = (commit && sr_q[14:8] == ADDR_DUTY)   ? sr_q[7:0] : duty_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q     <= '0;
            cnt_q    <= '0;
            armed_q  <= 1'b0;
            out_lo_q <= '0;
            out_hi_q <= '0;
            pwm_lo_q <= '0;
            pwm_hi_q <= '0;
            duty_q   <= '0;
            wr_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            sr_q     <= sr_d;
            cnt_q    <= cnt_d;
            armed_q  <= armed_d;
            out_lo_q <= out_lo_d;
            out_hi_q <= out_hi_d;
            pwm_lo_q <= pwm_lo_d;
            pwm_hi_q <= pwm_hi_d;
            duty_q   <= duty_d;
            wr_q     <= wr_d;
            err_q    <= err_d;
        end
    end
    assign en_reg_out_7_0  = out_lo_q;
    assign en_reg_out_15_8 = out_hi_q;
    assign en_reg_pwm_7_0  = pwm_lo_q;
    assign en_reg_pwm_15_8 = pwm_hi_q;
    assign pwm_duty_cycle  = duty_q;
    assign wr_strobe       = wr_q;
    assign frame_err       = err_q;
endmodule

// File: doc/spi_reg_ctrl.md
SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high. The top level drives it as ~rst_n.
REQ-003 SHALL have port sclk, input, 1 bit: SPI clock from ui_in[0]; asynchronous to clk.
REQ-004 SHALL have port copi, input, 1 bit: SPI data in from ui_in[1]; asynchronous.
REQ-005 SHALL have port ncs, input, 1 bit: SPI chip select from ui_in[2]; active-low, asynchronous.
REQ-006 SHALL have ports en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle, each output, 8 bits: configuration registers that drive pwm_peripheral.
REQ-007 SHALL have port wr_strobe, output, 1 bit: one-clk pulse on each register commit.
REQ-008 SHALL have port frame_err, output, 1 bit: one-clk pulse when a frame is discarded.

Function
REQ-009 SHALL pass each of sclk, copi and ncs through a 2-flop synchronizer plus one history flop.
- Edge detection uses only synchronized values.
REQ-010 SHALL use SPI mode 0: sample synchronized copi on each detected sclk rising edge while synchronized ncs=0; MSB first.
REQ-011 SHALL define a frame as 16 bits:
- bit15 = R/W (1 = write)
- bits14:8 = address
- bits7:0 = data
REQ-012 SHALL clear the shift register and the 5-bit bit counter on the detected ncs falling edge.
REQ-013 SHALL increment the bit counter per sampled bit, saturating at 17.
REQ-014 SHALL evaluate the frame on the detected ncs rising edge, which is the only commit point.
REQ-015 SHALL commit (write data to the addressed register, pulse wr_strobe) only when all of these hold:
- count == 16
- R/W == 1
- address <= 0x04
REQ-016 SHALL use this address map: 0x00 en_reg_out_7_0, 0x01 en_reg_out_15_8, 0x02 en_reg_pwm_7_0, 0x03 en_reg_pwm_15_8, 0x04 pwm_duty_cycle.
REQ-017 SHALL leave all registers unchanged and pulse frame_err when count != 16.
REQ-018 SHALL treat R/W=0 (reads unsupported) or an address above 0x04 as silently ignored: no register change, no wr_strobe, no frame_err.
REQ-019 SHALL ignore sclk edges while synchronized ncs=1.
REQ-020 SHALL discard an sclk rising edge detected in the same clk cycle as the ncs rising edge; ncs deassertion wins.
REQ-021 SHALL ignore an ncs rising edge with no preceding falling edge since reset.
REQ-022 SHALL make a written register visible exactly 3 clk rising edges after the first clk edge that samples raw ncs=1.
- wr_strobe is asserted in that same cycle.
REQ-023 SHALL operate correctly for sclk at or below clk/4 with each sclk phase at least 2 clk periods.
REQ-024 SHALL make the last committed value of each register persist indefinitely; outputs are registered, with no combinational path from inputs.

Reset
REQ-025 SHALL, while rst=1, clear all registers, the shift register, the bit counter, wr_strobe and frame_err, and set the synchronizer flops for ncs to 1 and for sclk/copi to 0.
REQ-026 SHALL discard any frame in progress when rst is asserted mid-frame; no commit follows the next ncs rising edge unless a new falling edge occurs.

Structure
REQ-027 SHALL place the following in package spi_reg_pkg:
- address constants ADDR_OUT_LO=0x00 .. ADDR_DUTY=0x04
- FRAME_BITS=16
- MAX_ADDR=0x04
REQ-028 SHALL use one sub-module, sync_edge_det (2-flop sync, history flop, rise/fall outputs, reset value parameter), instantiated three times.
REQ-029 SHALL fit in 120-400 lines of RTL, excluding the package.

Verification
REQ-030 SHALL cover: after reset, frame 0x8455 at sclk=clk/8 -> pwm_duty_cycle=0x55, one wr_strobe pulse, all other registers 0x00.
REQ-031 SHALL cover: frames 0x80F0, 0x81AA, 0x82FF, 0x8301 -> registers 0xF0, 0xAA, 0xFF, 0x01 respectively; exactly four wr_strobe pulses.
REQ-032 SHALL cover: 15-bit frame and 17-bit frame, each writing 0x80xx -> en_reg_out_7_0 unchanged, two frame_err pulses, no wr_strobe.
REQ-033 SHALL cover: frame 0x0412 (read) and frame 0x8533 (address 0x05) -> no register change, no wr_strobe, no frame_err.
REQ-034 SHALL cover: rst pulsed after 8 bits of frame 0x8477, then ncs raised -> pwm_duty_cycle=0x00, no wr_strobe; the following full frame 0x8477 commits 0x77.
REQ-035 SHALL cover: frame 0x8299 -> en_reg_pwm_7_0=0x99 exactly 3 clk edges after raw ncs rises; sclk toggling while ncs=1 changes nothing.
